// File: rtl/midi_pkg.sv
// midi_pkg: constants, types and helpers shared by the MIDI blocks (midi_rx, midi_note_fifo, midi_tx).
package midi_pkg;

  localparam logic [3:0]  MIDI_STATUS_NOTE_ON  = 4'h9;
  localparam logic [3:0]  MIDI_STATUS_NOTE_OFF = 4'h8;
  localparam int unsigned MIDI_BAUD            = 31250;
  localparam int unsigned MIDI_FRAME_BITS      = 10;
  localparam int unsigned MIDI_BIT_IDX_W       = 4;

  // One note event as carried on the valid/ready interface
  typedef struct packed {
    logic       off;
    logic [3:0] chan;
    logic [6:0] key;
    logic [6:0] vel;
  } midi_note_ev_t;

  typedef enum logic {
    UTX_IDLE,
    UTX_SHIFT
  } utx_state_t;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_SEND
  } seq_state_t;

  // Channel-voice status byte for a note on/off
  function automatic logic [7:0] midi_note_status(input logic off, input logic [3:0] chan);
    return {(off ? MIDI_STATUS_NOTE_OFF : MIDI_STATUS_NOTE_ON), chan};
  endfunction

endpackage

// File: rtl/midi_uart_tx.sv
// midi_uart_tx: 8N1 byte serializer. A byte offered during the last cycle of
// the previous stop bit is taken immediately, so bytes go out back-to-back.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [MIDI_BIT_IDX_W-1:0] BIT_LAST = MIDI_BIT_IDX_W'(MIDI_FRAME_BITS - 1);
  localparam logic [MIDI_BIT_IDX_W-1:0] BIT_PRE_STOP = MIDI_BIT_IDX_W'(MIDI_FRAME_BITS - 2);

  utx_state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_baud, w_baud_nxt;
  logic [MIDI_BIT_IDX_W-1:0] r_bit_idx, w_bit_idx_nxt;
  logic [7:0]                r_data, w_data_nxt;
  logic                      r_tx, w_tx_nxt;
  logic                      w_bit_end;
  logic                      w_load;

  assign w_bit_end  = (r_baud == CNT_LAST);
  assign byte_ready = (r_state == UTX_IDLE) || (w_bit_end && (r_bit_idx == BIT_LAST));
  assign w_load     = byte_valid && byte_ready;
  assign tx         = r_tx;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= UTX_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_data    <= w_data_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  // Next state: load a byte, count baud ticks, step through start/data/stop
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_data_nxt    = r_data;
    w_tx_nxt      = r_tx;
    if (w_load) begin
      w_state_nxt   = UTX_SHIFT;
      w_data_nxt    = byte_in;
      w_bit_idx_nxt = '0;
      w_baud_nxt    = '0;
      w_tx_nxt      = 1'b0;
    end else if (r_state == UTX_SHIFT) begin
      if (!w_bit_end) begin
        w_baud_nxt = r_baud + CNT_W'(1);
      end else begin
        w_baud_nxt = '0;
        if (r_bit_idx == BIT_LAST) begin
          w_state_nxt = UTX_IDLE;
          w_tx_nxt    = 1'b1;
        end else begin
          w_bit_idx_nxt = r_bit_idx + MIDI_BIT_IDX_W'(1);
          w_tx_nxt      = (r_bit_idx == BIT_PRE_STOP) ? 1'b1 : r_data[r_bit_idx[2:0]];
        end
      end
    end
  end

endmodule

// File: rtl/midi_tx.sv
// midi_tx: sequences one note event into a status/key/velocity message on the
// MIDI OUT line. Optional running status (skip a repeated status byte) is
// enabled by defining MIDI_RUNNING_STATUS_EN.
module midi_tx
  import midi_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       ev_off,
  input  logic [3:0] ev_chan,
  input  logic [6:0] ev_key,
  input  logic [6:0] ev_vel,
  output logic       tx,
  output logic       busy
);

  localparam logic [1:0] BYTE_LAST = 2'd2;

  seq_state_t    r_state, w_state_nxt;
  logic [1:0]    r_byte_idx, w_byte_idx_nxt;
  logic [6:0]    r_key, w_key_nxt;
  logic [6:0]    r_vel, w_vel_nxt;
  logic          r_ev_ready, w_ev_ready_nxt;
  logic          r_busy, w_busy_nxt;
  midi_note_ev_t w_ev;
  logic [7:0]    w_status;
  logic [7:0]    w_byte_in;
  logic          w_byte_valid;
  logic          w_byte_ready;
  logic          w_skip;
  logic          w_tx;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last_status, w_last_status_nxt;
  logic       r_last_valid, w_last_valid_nxt;
  assign w_skip = r_last_valid && (w_status == r_last_status);
`else
  assign w_skip = 1'b0;
`endif

  assign w_ev     = '{off: ev_off, chan: ev_chan, key: ev_key, vel: ev_vel};
  assign w_status = midi_note_status(w_ev.off, w_ev.chan);
  assign ev_ready = r_ev_ready;
  assign busy     = r_busy;
  assign tx       = w_tx;

  midi_uart_tx #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_uart (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (w_byte_in),
    .byte_valid(w_byte_valid),
    .byte_ready(w_byte_ready),
    .tx        (w_tx)
  );

  // Sequencer state, latched event fields and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= SEQ_IDLE;
      r_byte_idx    <= '0;
      r_key         <= '0;
      r_vel         <= '0;
      r_ev_ready    <= 1'b1;
      r_busy        <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      r_last_status <= '0;
      r_last_valid  <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_byte_idx    <= w_byte_idx_nxt;
      r_key         <= w_key_nxt;
      r_vel         <= w_vel_nxt;
      r_ev_ready    <= w_ev_ready_nxt;
      r_busy        <= w_busy_nxt;
`ifdef MIDI_RUNNING_STATUS_EN
      r_last_status <= w_last_status_nxt;
      r_last_valid  <= w_last_valid_nxt;
`endif
    end
  end

  // Next state: first byte goes straight to the serializer on accept; the
  // following bytes are handed over at the end of each stop bit
  always_comb begin
    w_state_nxt       = r_state;
    w_byte_idx_nxt    = r_byte_idx;
    w_key_nxt         = r_key;
    w_vel_nxt         = r_vel;
    w_ev_ready_nxt    = r_ev_ready;
    w_busy_nxt        = r_busy;
    w_byte_valid      = 1'b0;
    w_byte_in         = 8'h00;
`ifdef MIDI_RUNNING_STATUS_EN
    w_last_status_nxt = r_last_status;
    w_last_valid_nxt  = r_last_valid;
`endif
    case (r_state)
      SEQ_IDLE: begin
        w_byte_valid = ev_valid && r_ev_ready;
        w_byte_in    = w_skip ? {1'b0, w_ev.key} : w_status;
        if (ev_valid && r_ev_ready) begin
          w_key_nxt      = w_ev.key;
          w_vel_nxt      = w_ev.vel;
          w_byte_idx_nxt = w_skip ? 2'd1 : 2'd0;
          w_state_nxt    = SEQ_SEND;
          w_ev_ready_nxt = 1'b0;
          w_busy_nxt     = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
          if (!w_skip) begin
            w_last_status_nxt = w_status;
            w_last_valid_nxt  = 1'b1;
          end
`endif
        end
      end
      SEQ_SEND: begin
        w_byte_valid = (r_byte_idx != BYTE_LAST);
        w_byte_in    = (r_byte_idx == 2'd0) ? {1'b0, r_key} : {1'b0, r_vel};
        if (w_byte_ready) begin
          if (r_byte_idx == BYTE_LAST) begin
            w_state_nxt    = SEQ_IDLE;
            w_byte_idx_nxt = 2'd0;
            w_ev_ready_nxt = 1'b1;
            w_busy_nxt     = 1'b0;
          end else begin
            w_byte_idx_nxt = r_byte_idx + 2'd1;
          end
        end
      end
      default: begin
        w_state_nxt = SEQ_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: directed bench for midi_tx with BIT_CYCLES=16. Expected frames
// follow the running-status setting chosen by MIDI_RUNNING_STATUS_EN.
module tb_midi_tx;

  localparam int unsigned BC = 16;

  logic       clk;
  logic       rst;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_off;
  logic [3:0] ev_chan;
  logic [6:0] ev_key;
  logic [6:0] ev_vel;
  logic       tx;
  logic       busy;

  int n_cmp;
  int n_err;

  midi_tx #(
    .BIT_CYCLES(BC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_off  (ev_off),
    .ev_chan (ev_chan),
    .ev_key  (ev_key),
    .ev_vel  (ev_vel),
    .tx      (tx),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Present one event for exactly one accepting edge, then drop valid
  task automatic send_event(input logic off, input logic [3:0] ch, input logic [6:0] key,
                            input logic [6:0] vel, input string tag);
    ev_off   = off;
    ev_chan  = ch;
    ev_key   = key;
    ev_vel   = vel;
    ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
    ev_off   = ~off;
    ev_chan  = 4'hF;
    ev_key   = 7'h55;
    ev_vel   = 7'h2A;
    check({tag, " ready_low_after_accept"}, 32'(ev_ready), 32'd0);
    check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
  endtask

  // Called at the first cycle of the first start bit; checks every bit for
  // exactly BC cycles, then the return of ready
  task automatic expect_frame(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input bit scramble, input string tag);
    logic [7:0]  bytes [3];
    logic [9:0]  frame;
    logic [15:0] samp;
    logic        hold_ok;
    bytes[0] = b0;
    bytes[1] = b1;
    bytes[2] = b2;
    hold_ok  = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      frame = {1'b1, bytes[b], 1'b0};
      for (int k = 0; k < 10; k++) begin
        for (int c = 0; c < 16; c++) begin
          samp[c] = tx;
          if (!(busy === 1'b1 && ev_ready === 1'b0)) hold_ok = 1'b0;
          if (scramble) begin
            ev_off  = 1'($urandom);
            ev_chan = 4'($urandom);
            ev_key  = 7'($urandom);
            ev_vel  = 7'($urandom);
          end
          tick();
        end
        check($sformatf("%s byte%0d bit%0d", tag, b, k), 32'(samp),
              frame[k] ? 32'h0000FFFF : 32'h0);
      end
    end
    check({tag, " busy_held"}, 32'(hold_ok), 32'd1);
    check({tag, " ready_back"}, 32'(ev_ready), 32'd1);
    check({tag, " busy_clear"}, 32'(busy), 32'd0);
    check({tag, " tx_idle"}, 32'(tx), 32'd1);
  endtask

  initial begin
    logic [15:0] idle_samp;
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    ev_valid = 1'b0;
    ev_off   = 1'b0;
    ev_chan  = 4'h0;
    ev_key   = 7'h00;
    ev_vel   = 7'h00;
    tick();
    tick();
    tick();
    rst = 1'b0;

    check("reset tx", 32'(tx), 32'd1);
    check("reset ev_ready", 32'(ev_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    tick();

    // Note-on chan 0: 0x90 0x3C 0x64, ready back after 480 cycles
    send_event(1'b0, 4'h0, 7'h3C, 7'h64, "on0");
    expect_frame(3, 8'h90, 8'h3C, 8'h64, 1'b0, "on0");

    // Note-off chan 3: 0x83 0x45 0x40
    send_event(1'b1, 4'h3, 7'h45, 7'h40, "off3");
    expect_frame(3, 8'h83, 8'h45, 8'h40, 1'b0, "off3");

    // Valid held with changing fields during busy
    ev_off   = 1'b0;
    ev_chan  = 4'h1;
    ev_key   = 7'h10;
    ev_vel   = 7'h20;
    ev_valid = 1'b1;
    tick();
    check("held first accept", 32'(ev_ready), 32'd0);
    expect_frame(3, 8'h91, 8'h10, 8'h20, 1'b1, "heldA");
    ev_off  = 1'b0;
    ev_chan = 4'h1;
    ev_key  = 7'h11;
    ev_vel  = 7'h22;
    tick();
    ev_valid = 1'b0;
    check("heldB accepted first ready cycle", 32'(ev_ready), 32'd0);
    check("heldB start bit", 32'(tx), 32'd0);
`ifdef MIDI_RUNNING_STATUS_EN
    expect_frame(2, 8'h11, 8'h22, 8'h00, 1'b0, "heldB");
`else
    expect_frame(3, 8'h91, 8'h11, 8'h22, 1'b0, "heldB");
`endif

    // Reset during byte 1 bit 4 (key 0x50 -> that bit is 0)
    send_event(1'b0, 4'h2, 7'h50, 7'h10, "abort");
    for (int i = 0; i < 230; i++) tick();
    check("abort tx low before reset", 32'(tx), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort tx after reset", 32'(tx), 32'd1);
    check("abort ready after reset", 32'(ev_ready), 32'd1);
    check("abort busy after reset", 32'(busy), 32'd0);
    for (int c = 0; c < 16; c++) begin
      idle_samp[c] = tx;
      tick();
    end
    check("abort not resumed", 32'(idle_samp), 32'h0000FFFF);

    send_event(1'b0, 4'h5, 7'h30, 7'h7F, "on5");
    expect_frame(3, 8'h95, 8'h30, 8'h7F, 1'b0, "on5");

    // Two identical note-ons then a note-off on chan 0
    send_event(1'b0, 4'h0, 7'h3C, 7'h64, "rs1");
    expect_frame(3, 8'h90, 8'h3C, 8'h64, 1'b0, "rs1");
    send_event(1'b0, 4'h0, 7'h3C, 7'h64, "rs2");
`ifdef MIDI_RUNNING_STATUS_EN
    expect_frame(2, 8'h3C, 8'h64, 8'h00, 1'b0, "rs2");
`else
    expect_frame(3, 8'h90, 8'h3C, 8'h64, 1'b0, "rs2");
`endif
    send_event(1'b1, 4'h0, 7'h3C, 7'h40, "rs3");
    expect_frame(3, 8'h80, 8'h3C, 8'h40, 1'b0, "rs3");

    // After reset, a repeat of the last status still carries the status byte
    do_reset();
    tick();
    send_event(1'b1, 4'h0, 7'h3C, 7'h40, "post_rst");
    expect_frame(3, 8'h80, 8'h3C, 8'h40, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Transmit-side counterpart of midi_rx: serializes note events onto a MIDI OUT line, 31250 baud, 8N1.
- Takes one note-on/note-off event per valid/ready handshake and emits a 3-byte MIDI channel message: status, key, velocity.
- Sits in the clk domain beside midi_rx/midi_note_fifo. Uses: echo/thru of played notes, or sequencer output to an external synth.

Parameters:
- BIT_CYCLES, 1600, clk cycles per MIDI bit (50 MHz / 31250); benches override to 16.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- ev_valid  in  1  event present
- ev_ready  out  1  block can accept an event this cycle
- ev_off  in  1  1 = note off, 0 = note on
- ev_chan  in  4  MIDI channel 0..15
- ev_key  in  7  key number
- ev_vel  in  7  velocity (release velocity for note off)
- tx  out  1  MIDI serial line, idle high
- busy  out  1  frame in progress

Behaviour:
- Reset: rst is synchronous, active-high, on clock clk.
  - All outputs registered. Reset values: tx=1, ev_ready=1, busy=0.
  - Reset clears all counters and state to IDLE.
- Accept: on a clk edge with ev_valid&ev_ready, latch all event fields.
  - Next cycle: ev_ready=0, busy=1.
  - Inputs are ignored while ev_ready=0.
- Bytes sent, in order:
  - status = {ev_off ? 4'h8 : 4'h9, ev_chan}
  - data1 = {1'b0, ev_key}
  - data2 = {1'b0, ev_vel}
- Frame per byte:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit held exactly BIT_CYCLES clocks.
  - Bytes go back-to-back with no idle gap.
- Latency: tx drives the first start bit beginning the cycle after accept.
- Completion:
  - The final stop bit lasts a full BIT_CYCLES.
  - ev_ready=1 and busy=0 from the cycle after the stop bit completes.
  - Full frame = 30*BIT_CYCLES cycles from first start bit to ready.
- FSM:
  - IDLE -> (accept) -> SEND.
  - SEND steps through a byte index (0..2, or 1..2 under the optional feature) and a bit index 0..9.
  - Last stop bit of byte 2 -> IDLE.
- Counters:
  - Baud counter width $clog2(BIT_CYCLES), counts 0..BIT_CYCLES-1 and wraps.
  - Bit index advances on wrap; byte index advances when the bit index wraps from 9.
- Reset mid-frame: tx=1 on the next edge. The partial byte is abandoned, never resumed. The next event sends a complete frame.
- ev_valid held during busy: no effect. The event is accepted on the first cycle ev_ready returns high.

Optional Feature:
- Macro MIDI_RUNNING_STATUS_EN.
- Defined:
  - Register last_status and a last_valid flag; last_valid=0 on reset.
  - If the new event's status equals last_status and last_valid=1, skip the status byte: 2 bytes, 20*BIT_CYCLES.
  - Otherwise send 3 bytes and update last_status, setting last_valid=1.
  - A reset mid-frame clears last_valid.
- Undefined: every event sends all 3 bytes and no status register exists.

Decomposition:
- Package midi_pkg: MIDI_STATUS_NOTE_ON=4'h9, MIDI_STATUS_NOTE_OFF=4'h8, MIDI_BAUD=31250, frame bit count 10.
- Share midi_pkg with midi_rx/midi_note_fifo.
- Sub-module midi_uart_tx, the byte serializer:
  - Ports: clk, rst, byte_in[8], byte_valid, byte_ready, tx.
  - midi_tx is the message sequencer above it.

Test Plan (BIT_CYCLES=16):
- Note-on: chan 0, key 0x3C, vel 0x64 -> tx carries bytes 0x90, 0x3C, 0x64 LSB-first.
  - First start bit goes low the cycle after accept.
  - ev_ready returns 480 cycles later.
- Note-off: chan 3, key 0x45, vel 0x40 -> bytes 0x83, 0x45, 0x40.
  - Every bit lasts exactly 16 cycles.
  - Stop bits are 1, with no gap between bytes.
- ev_valid held high with changing fields during busy -> nothing sampled mid-frame. The second event is accepted exactly on the first ev_ready=1 cycle and transmits its own fields.
- rst pulsed during byte 1, bit 4 -> tx=1 next cycle, ev_ready=1, busy=0.
  - Following note-on chan 5, key 0x30, vel 0x7F -> full 0x95, 0x30, 0x7F.
- Macro defined:
  - Two note-ons on chan 0 -> the second frame is 0x3C, 0x64 only (320 cycles).
  - A following note-off on chan 0 -> 3 bytes starting 0x80.
  - After reset, the first event always includes its status byte.
- Macro undefined: the same sequence yields three 3-byte frames.
